// File: rtl/fwd_bypass_net_pkg.sv
// Shared constants for the operand-bypass network: forward-select encoding
// and the helper that maps a scoreboard stage index onto its select code.
package fwd_bypass_net_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] FWD_RF   = 2'd0;
  localparam logic [SEL_W-1:0] FWD_STG0 = 2'd1;

  // Select code for stage k: RF is 0, stage k is k+1.
  function automatic logic [SEL_W-1:0] fwd_stage(input int k);
    return FWD_STG0 + SEL_W'(k);
  endfunction

endpackage

// File: rtl/fwd_bypass_net_port_sel.sv
// One read port of the bypass network: priority match of the source register
// against the scoreboard, youngest (lowest stage index) entry first.
module fwd_bypass_net_port_sel
  import fwd_bypass_net_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2
) (
  input  logic [AW-1:0]         rs_addr,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [DEPTH-1:0]      sb_valid,
  input  logic [DEPTH*AW-1:0]   sb_rd,
  input  logic [DEPTH-1:0]      sb_load,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]       data,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    data   = rf_data;
    sel    = FWD_RF;
    hazard = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing,
    // even when that youngest producer is a load whose data is not ready yet.
    if (rs_addr != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (sb_valid[k] && sb_rd[k*AW +: AW] == rs_addr) begin
          if (!sb_load[k] || k >= LOAD_RDY) begin
            data   = stage_data[k*XLEN +: XLEN];
            sel    = fwd_stage(k);
            hazard = 1'b0;
          end else begin
            data   = rf_data;
            sel    = FWD_RF;
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_net.sv
// Operand-bypass network: scoreboard of in-flight destinations, per-port
// forwarding, load-use stall generation and a saturating hazard counter.
module fwd_bypass_net
  import fwd_bypass_net_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    iss_valid_i,
  input  logic [AW-1:0]           iss_rd_i,
  input  logic                    iss_load_i,
  input  logic [DEPTH*XLEN-1:0]   stage_data_i,
  input  logic [NREAD*AW-1:0]     rs_addr_i,
  input  logic [NREAD*XLEN-1:0]   rf_data_i,
  output logic [NREAD*XLEN-1:0]   fwd_data_o,
  output logic [NREAD*SEL_W-1:0]  fwd_sel_o,
  output logic                    hazard_stall_o,
  output logic [CNT_W-1:0]        hazard_cnt_o
);

  logic [DEPTH-1:0]    sb_valid;
  logic [DEPTH*AW-1:0] sb_rd;
  logic [DEPTH-1:0]    sb_load;
  logic [NREAD-1:0]    port_hazard;
  logic                issue_ok;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_bypass_net_port_sel #(
      .XLEN     (XLEN),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_RDY (LOAD_RDY)
    ) u_port_sel (
      .rs_addr    (rs_addr_i[p*AW +: AW]),
      .rf_data    (rf_data_i[p*XLEN +: XLEN]),
      .sb_valid   (sb_valid),
      .sb_rd      (sb_rd),
      .sb_load    (sb_load),
      .stage_data (stage_data_i),
      .data       (fwd_data_o[p*XLEN +: XLEN]),
      .sel        (fwd_sel_o[p*SEL_W +: SEL_W]),
      .hazard     (port_hazard[p])
    );
  end

  // A stall is only meaningful when a real instruction is waiting in ID.
  assign hazard_stall_o = iss_valid_i && (|port_hazard);

  // x0 destinations are never tracked; a stalled or flushed issue becomes a bubble.
  assign issue_ok = iss_valid_i && !flush_i && !hazard_stall_o && (iss_rd_i != '0);

  // NOTE: the scoreboard is a handful of flops, so all of it is reset; only valid matters but clearing every field keeps X out of the match logic.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state is always written with non-blocking assignments.
      sb_valid <= '0;
      sb_rd    <= '0;
      sb_load  <= '0;
    end else if (!stall_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_valid[k]         <= sb_valid[k-1];
        sb_rd[k*AW +: AW]   <= sb_rd[(k-1)*AW +: AW];
        sb_load[k]          <= sb_load[k-1];
      end
      sb_valid[0]  <= issue_ok;
      sb_rd[0 +: AW] <= issue_ok ? iss_rd_i : '0;
      sb_load[0]   <= issue_ok && iss_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hazard_cnt_o <= '0;
    end else if (!stall_i && hazard_stall_o && (hazard_cnt_o != '1)) begin
      hazard_cnt_o <= hazard_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed and randomized checks of fwd_bypass_net against an age-ordered
// history of issued instructions kept by the bench.
module tb_fwd_bypass_net;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NREAD    = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 2;
  localparam int CNT_W    = 4;   // narrow counter so saturation is reachable quickly
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                   clk_i;
  logic                   rst_n_i;
  logic                   stall_i;
  logic                   flush_i;
  logic                   iss_valid_i;
  logic [AW-1:0]          iss_rd_i;
  logic                   iss_load_i;
  logic [DEPTH*XLEN-1:0]  stage_data_i;
  logic [NREAD*AW-1:0]    rs_addr_i;
  logic [NREAD*XLEN-1:0]  rf_data_i;
  logic [NREAD*XLEN-1:0]  fwd_data_o;
  logic [NREAD*2-1:0]     fwd_sel_o;
  logic                   hazard_stall_o;
  logic [CNT_W-1:0]       hazard_cnt_o;

  fwd_bypass_net #(
    .XLEN(XLEN), .AW(AW), .NREAD(NREAD), .DEPTH(DEPTH),
    .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .iss_valid_i    (iss_valid_i),
    .iss_rd_i       (iss_rd_i),
    .iss_load_i     (iss_load_i),
    .stage_data_i   (stage_data_i),
    .rs_addr_i      (rs_addr_i),
    .rf_data_i      (rf_data_i),
    .fwd_data_o     (fwd_data_o),
    .fwd_sel_o      (fwd_sel_o),
    .hazard_stall_o (hazard_stall_o),
    .hazard_cnt_o   (hazard_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // hist[age]: instruction that entered EX 'age' unstalled cycles ago.
  typedef struct {
    bit valid;
    int rd;
    bit load;
  } rec_t;

  rec_t hist[$];
  int   model_cnt;
  int   checks;
  int   failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_t r;
    r.valid = 1'b0;
    r.rd    = 0;
    r.load  = 1'b0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(r);
    model_cnt = 0;
  endtask

  // Youngest in-flight writer of the source register decides the operand.
  task automatic expect_port(input int p, output logic [XLEN-1:0] d,
                             output logic [1:0] s, output bit hz);
    int a;
    a  = int'(rs_addr_i[p*AW +: AW]);
    d  = rf_data_i[p*XLEN +: XLEN];
    s  = 2'd0;
    hz = 1'b0;
    if (a != 0) begin
      for (int age = 0; age < DEPTH; age++) begin
        if (hist[age].valid && hist[age].rd == a) begin
          if (!hist[age].load || age >= LOAD_RDY) begin
            d = stage_data_i[age*XLEN +: XLEN];
            s = 2'(age + 1);
          end else begin
            hz = 1'b1;
          end
          break;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag, output bit exp_stall);
    logic [XLEN-1:0] d;
    logic [1:0]      s;
    bit              hz;
    bit              any_hz;
    any_hz = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      expect_port(p, d, s, hz);
      check($sformatf("%s_data%0d", tag, p), 64'(fwd_data_o[p*XLEN +: XLEN]), 64'(d));
      check($sformatf("%s_sel%0d", tag, p), 64'(fwd_sel_o[p*2 +: 2]), 64'(s));
      any_hz |= hz;
    end
    exp_stall = iss_valid_i && any_hz;
    check({tag, "_stall"}, 64'(hazard_stall_o), 64'(exp_stall));
    check({tag, "_cnt"}, 64'(hazard_cnt_o), 64'(model_cnt));
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    bit   exp_stall;
    rec_t r;
    @(negedge clk_i);
    compare_all(tag, exp_stall);
    @(posedge clk_i);
    if (!stall_i) begin
      if (exp_stall && model_cnt < CNT_MAX) model_cnt++;
      r.valid = iss_valid_i && !flush_i && !exp_stall && (iss_rd_i != '0);
      r.rd    = int'(iss_rd_i);
      r.load  = iss_load_i;
      hist.push_front(r);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rd, input bit ld,
                       input int rs0, input int rs1, input bit st, input bit fl);
    iss_valid_i = v;
    iss_rd_i    = AW'(rd);
    iss_load_i  = ld;
    rs_addr_i   = {AW'(rs1), AW'(rs0)};
    stall_i     = st;
    flush_i     = fl;
  endtask

  int  saved_cnt;
  bit  dummy;

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst_n_i      = 1'b0;
    drive(0, 0, 0, 5, 0, 0, 0);
    rf_data_i    = {32'h22, 32'h11};
    stage_data_i = {32'hC2, 32'hB1, 32'hAA};

    // Reset: outputs follow RF immediately.
    #2;
    check("rst_data0", 64'(fwd_data_o[XLEN-1:0]), 64'h11);
    check("rst_sel0", 64'(fwd_sel_o[1:0]), 64'd0);
    check("rst_stall", 64'(hazard_stall_o), 64'd0);
    check("rst_cnt", 64'(hazard_cnt_o), 64'd0);
    #10 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // ALU back-to-back forward from EX.
    drive(1, 5, 0, 0, 0, 0, 0); cycle("alu_iss");
    drive(1, 6, 0, 5, 0, 0, 0);
    #1;
    check("alu_data", 64'(fwd_data_o[XLEN-1:0]), 64'hAA);
    check("alu_sel", 64'(fwd_sel_o[1:0]), 64'd1);
    check("alu_stall", 64'(hazard_stall_o), 64'd0);
    cycle("alu_use");

    // Load-use: two stall cycles, then forward from stage 2.
    drive(1, 7, 1, 0, 0, 0, 0); cycle("ld_iss");
    drive(1, 8, 0, 7, 0, 0, 0);
    #1 check("ld_stall_a", 64'(hazard_stall_o), 64'd1);
    cycle("ld_wait1");
    #1 check("ld_stall_b", 64'(hazard_stall_o), 64'd1);
    cycle("ld_wait2");
    #1;
    check("ld_stall_c", 64'(hazard_stall_o), 64'd0);
    check("ld_data", 64'(fwd_data_o[XLEN-1:0]), 64'hC2);
    check("ld_sel", 64'(fwd_sel_o[1:0]), 64'd3);
    check("ld_cnt", 64'(hazard_cnt_o), 64'd2);
    cycle("ld_go");

    // Youngest producer wins; x0 is never forwarded.
    drive(1, 3, 0, 0, 0, 0, 0); cycle("yw_a");
    drive(1, 3, 0, 0, 0, 0, 0); cycle("yw_b");
    stage_data_i = {32'hC2, 32'h1, 32'h2};
    drive(1, 0, 0, 3, 0, 0, 0);
    #1;
    check("yw_data0", 64'(fwd_data_o[XLEN-1:0]), 64'h2);
    check("yw_sel0", 64'(fwd_sel_o[1:0]), 64'd1);
    check("yw_data1", 64'(fwd_data_o[2*XLEN-1:XLEN]), 64'h22);
    check("yw_sel1", 64'(fwd_sel_o[3:2]), 64'd0);
    cycle("yw_use");

    // Younger unready load shadows an older ready ALU result.
    drive(1, 4, 0, 0, 0, 0, 0); cycle("sh_alu");
    drive(1, 4, 1, 0, 0, 0, 0); cycle("sh_ld");
    drive(1, 0, 0, 4, 0, 0, 0);
    #1 check("sh_stall", 64'(hazard_stall_o), 64'd1);
    cycle("sh_w1"); cycle("sh_w2"); cycle("sh_go");

    // Global stall freezes scoreboard and counter.
    drive(1, 10, 1, 0, 0, 0, 0); cycle("st_iss");
    saved_cnt = model_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(1, 11, 0, 10, 0, 1, 0);
      cycle($sformatf("st_hold%0d", i));
      check($sformatf("st_cnt%0d", i), 64'(hazard_cnt_o), 64'(saved_cnt));
    end
    drive(1, 11, 0, 10, 0, 0, 0);
    cycle("st_rel1"); cycle("st_rel2"); cycle("st_rel3");

    // Flush: killed issue is not tracked.
    drive(1, 9, 0, 0, 0, 0, 1); cycle("fl_iss");
    drive(1, 0, 0, 9, 0, 0, 0);
    #1;
    check("fl_sel", 64'(fwd_sel_o[1:0]), 64'd0);
    check("fl_data", 64'(fwd_data_o[XLEN-1:0]), 64'h11);
    cycle("fl_use");

    // Counter saturation.
    for (int i = 0; i < 10; i++) begin
      drive(1, 12, 1, 0, 0, 0, 0); cycle("sat_iss");
      drive(1, 0, 0, 12, 0, 0, 0);
      cycle("sat_w1"); cycle("sat_w2"); cycle("sat_go");
    end
    check("sat_cnt", 64'(hazard_cnt_o), 64'(CNT_MAX));

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 400; n++) begin
      stage_data_i = {$urandom, $urandom, $urandom};
      rf_data_i    = {$urandom, $urandom};
      drive($urandom_range(3, 0) != 0, $urandom_range(3, 0), $urandom_range(2, 0) == 0,
            $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
      if (n == 200) begin
        rst_n_i = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_rst", dummy);
        #1 rst_n_i = 1'b1;
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
